varredura_roteamento: RTL and testbench

VARREDURA_ROTEAMENTO -- requirements
Module: varredura_roteamento

---
 rtl/roteamento_pkg.sv | 14 +
 rtl/banco_canais.sv | 49 ++++
 rtl/varredura_roteamento.sv | 164 ++++++++++++++++
 tb/tb_varredura_roteamento.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roteamento_pkg.sv
// Shared widths and FSM state type for the channel scan router.
package roteamento_pkg;

  localparam int unsigned BITS     = 4;
  localparam int unsigned SEL_BITS = 2;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPresent,
    StDone
  } state_t;

endpackage

// File: rtl/banco_canais.sv
// Channel register bank with combinational read mux; optional written flags
// under SKIP_EMPTY_EN.
module banco_canais #(
  parameter int unsigned BITS     = 4,
  parameter int unsigned SEL_BITS = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_wr_en,
  input  logic [SEL_BITS-1:0]       i_wr_addr,
  input  logic [BITS-1:0]           i_wr_data,
  input  logic [SEL_BITS-1:0]       i_rd_addr,
  output logic [BITS-1:0]           o_rd_data
`ifdef SKIP_EMPTY_EN
  ,
  output logic [(1<<SEL_BITS)-1:0]  o_written
`endif
);

  localparam int unsigned NumCh = 1 << SEL_BITS;

  logic [BITS-1:0] r_mem [NumCh];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NumCh; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Reads see the pre-write value, so a same-cycle write and load capture old data.
  assign o_rd_data = r_mem[i_rd_addr];

`ifdef SKIP_EMPTY_EN
  logic [NumCh-1:0] r_written;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_written <= '0;
    end else if (i_wr_en) begin
      r_written[i_wr_addr] <= 1'b1;
    end
  end

  assign o_written = r_written;
`endif

endmodule

// File: rtl/varredura_roteamento.sv
// Scans the channel bank and presents each word on a valid/ready output.
// Define SKIP_EMPTY_EN to present only channels that have been written.
module varredura_roteamento
  import roteamento_pkg::*;
#(
  parameter int unsigned BITS     = roteamento_pkg::BITS,
  parameter int unsigned SEL_BITS = roteamento_pkg::SEL_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [SEL_BITS-1:0] wr_addr,
  input  logic [BITS-1:0]     wr_data,
  input  logic                start,
  input  logic                continuo,
  input  logic                stop,
  output logic [SEL_BITS-1:0] SEL,
  output logic [BITS-1:0]     Saida,
  output logic                saida_valid,
  input  logic                saida_ready,
  output logic                busy,
  output logic                done
);

  localparam int unsigned NumCh = 1 << SEL_BITS;

  state_t              r_state;
  logic [SEL_BITS-1:0] r_sel;
  logic [BITS-1:0]     r_saida;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_cont;
  logic                r_stop_req;

  logic [BITS-1:0]     w_rd_data;
  logic [SEL_BITS-1:0] w_first;
  logic [SEL_BITS-1:0] w_next;
  logic                w_is_last;
  logic                w_xfer;
  logic                w_stop;

`ifdef SKIP_EMPTY_EN
  logic [NumCh-1:0]    w_written;
  logic                w_any;
`endif

  banco_canais #(
    .BITS     (BITS),
    .SEL_BITS (SEL_BITS)
  ) u_banco (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_sel),
    .o_rd_data (w_rd_data)
`ifdef SKIP_EMPTY_EN
    ,
    .o_written (w_written)
`endif
  );

`ifdef SKIP_EMPTY_EN
  // Downward scan leaves the lowest written channel in w_first and the
  // closest written channel above r_sel in w_next.
  always_comb begin
    w_any     = |w_written;
    w_first   = '0;
    w_next    = r_sel;
    w_is_last = 1'b1;
    for (int i = NumCh - 1; i >= 0; i--) begin
      if (w_written[i]) begin
        w_first = SEL_BITS'(i);
        if (SEL_BITS'(i) > r_sel) begin
          w_next    = SEL_BITS'(i);
          w_is_last = 1'b0;
        end
      end
    end
  end
`else
  always_comb begin
    w_first   = '0;
    w_next    = r_sel + 1'b1;
    w_is_last = (r_sel == SEL_BITS'(NumCh - 1));
  end
`endif

  assign w_xfer = (r_state == StPresent) && r_valid && saida_ready;
  // A stop arriving on the transfer cycle itself still ends the scan there.
  assign w_stop = r_stop_req || (stop && r_cont);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_sel      <= '0;
      r_saida    <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cont     <= 1'b0;
      r_stop_req <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done     <= 1'b0;
          r_stop_req <= 1'b0;
          if (start) begin
            r_cont <= continuo;
            r_busy <= 1'b1;
`ifdef SKIP_EMPTY_EN
            if (!w_any) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_sel   <= w_first;
              r_state <= StLoad;
            end
`else
            r_sel   <= w_first;
            r_state <= StLoad;
`endif
          end
        end
        StLoad: begin
          r_saida <= w_rd_data;
          r_valid <= 1'b1;
          r_state <= StPresent;
          if (stop && r_cont) r_stop_req <= 1'b1;
        end
        StPresent: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
            if (w_stop || (w_is_last && !r_cont)) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_sel   <= w_is_last ? w_first : w_next;
              r_state <= StLoad;
            end
          end else if (stop && r_cont) begin
            r_stop_req <= 1'b1;
          end
        end
        StDone: begin
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_stop_req <= 1'b0;
          r_state    <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign SEL         = r_sel;
  assign Saida       = r_saida;
  assign saida_valid = r_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_varredura_roteamento.sv
// Directed bench for varredura_roteamento; skip-empty scenario runs only
// when SKIP_EMPTY_EN is defined.
module tb_varredura_roteamento;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       start;
  logic       continuo;
  logic       stop;
  logic [1:0] sel;
  logic [3:0] saida;
  logic       saida_valid;
  logic       saida_ready;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  varredura_roteamento #(
    .BITS     (4),
    .SEL_BITS (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .continuo    (continuo),
    .stop        (stop),
    .SEL         (sel),
    .Saida       (saida),
    .saida_valid (saida_valid),
    .saida_ready (saida_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      cycle();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; continuo = 1'b0; stop = 1'b0; saida_ready = 1'b0;
    repeat (2) cycle();
    n_vec++;
    if ({sel, saida, saida_valid, busy, done} !== 9'd0) begin
      $display("FAIL reset_held got %b exp 0", {sel, saida, saida_valid, busy, done});
      n_err++;
    end
    reset = 1'b0;
    cycle();
    n_vec++;
    if ({sel, saida, saida_valid, busy, done} !== 9'd0) begin
      $display("FAIL reset_released got %b exp 0", {sel, saida, saida_valid, busy, done});
      n_err++;
    end
  endtask

  task automatic test_single_sweep();
    logic [6:0] exp;
    for (int c = 0; c < 4; c++) wr(2'(c), 4'(c + 1));
    saida_ready = 1'b1; continuo = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    n_vec++;
    if ({busy, saida_valid} !== 2'b10) begin
      $display("FAIL sweep_load got busy/valid %b exp 10", {busy, saida_valid});
      n_err++;
    end
    for (int k = 0; k < 4; k++) begin
      cycle();
      exp = {1'b1, 2'(k), 4'(k + 1)};
      n_vec++;
      if ({saida_valid, sel, saida} !== exp) begin
        $display("FAIL sweep_word%0d got %b exp %b", k, {saida_valid, sel, saida}, exp);
        n_err++;
      end
      cycle();
      n_vec++;
      if ({saida_valid, done} !== {1'b0, (k == 3)}) begin
        $display("FAIL sweep_gap%0d got valid/done %b exp %b", k, {saida_valid, done},
                 {1'b0, (k == 3)});
        n_err++;
      end
    end
    cycle();
    n_vec++;
    if ({done, busy} !== 2'b00) begin
      $display("FAIL sweep_end got done/busy %b exp 00", {done, busy});
      n_err++;
    end
  endtask

  task automatic test_write_during_load();
    int n;
    saida_ready = 1'b1; continuo = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    // Now in LOAD for channel 1; the write lands on the same edge as the capture.
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'hA;
    cycle();
    wr_en = 1'b0;
    n_vec++;
    if ({saida_valid, sel, saida} !== {1'b1, 2'd1, 4'd2}) begin
      $display("FAIL war_capture got %b exp %b", {saida_valid, sel, saida},
               {1'b1, 2'd1, 4'd2});
      n_err++;
    end
    drain(n);
    wr(2'd1, 4'd2);
  endtask

  task automatic test_backpressure();
    int n;
    saida_ready = 1'b1; continuo = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    saida_ready = 1'b0;
    cycle();
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'd9;
    for (int i = 0; i < 5; i++) begin
      cycle();
      wr_en = 1'b0;
      n_vec++;
      if ({saida_valid, sel, saida} !== {1'b1, 2'd1, 4'd2}) begin
        $display("FAIL bp_stall%0d got %b exp %b", i, {saida_valid, sel, saida},
                 {1'b1, 2'd1, 4'd2});
        n_err++;
      end
    end
    saida_ready = 1'b1;
    cycle();
    n_vec++;
    if (saida_valid !== 1'b0) begin
      $display("FAIL bp_release got valid %b exp 0", saida_valid);
      n_err++;
    end
    cycle();
    n_vec++;
    if ({saida_valid, sel, saida} !== {1'b1, 2'd2, 4'd3}) begin
      $display("FAIL bp_advance got %b exp %b", {saida_valid, sel, saida},
               {1'b1, 2'd2, 4'd3});
      n_err++;
    end
    drain(n);
    wr(2'd1, 4'd2);
  endtask

  task automatic test_cont_stop();
    saida_ready = 1'b1; continuo = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    saida_ready = 1'b0;
    cycle();
    n_vec++;
    if ({saida_valid, sel, saida} !== {1'b1, 2'd2, 4'd3}) begin
      $display("FAIL stop_ch2 got %b exp %b", {saida_valid, sel, saida}, {1'b1, 2'd2, 4'd3});
      n_err++;
    end
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    n_vec++;
    if ({saida_valid, sel, done} !== {1'b1, 2'd2, 1'b0}) begin
      $display("FAIL stop_hold got %b exp %b", {saida_valid, sel, done}, {1'b1, 2'd2, 1'b0});
      n_err++;
    end
    saida_ready = 1'b1;
    cycle();
    n_vec++;
    if ({done, saida_valid, sel} !== {1'b1, 1'b0, 2'd2}) begin
      $display("FAIL stop_done got %b exp %b", {done, saida_valid, sel}, {1'b1, 1'b0, 2'd2});
      n_err++;
    end
    cycle();
    n_vec++;
    if ({done, busy, saida_valid} !== 3'b000) begin
      $display("FAIL stop_idle got %b exp 000", {done, busy, saida_valid});
      n_err++;
    end
    repeat (3) cycle();
    n_vec++;
    if ({saida_valid, busy} !== 2'b00) begin
      $display("FAIL stop_nowrap got %b exp 00", {saida_valid, busy});
      n_err++;
    end
    continuo = 1'b0;
  endtask

  task automatic test_wrap();
    logic [6:0] exp;
    int n;
    saida_ready = 1'b1; continuo = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      exp = {1'b1, 2'(k % 4), 4'((k % 4) + 1)};
      n_vec++;
      if ({saida_valid, sel, saida} !== exp) begin
        $display("FAIL wrap_word%0d got %b exp %b", k, {saida_valid, sel, saida}, exp);
        n_err++;
      end
      cycle();
    end
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    drain(n);
    n_vec++;
    if (busy !== 1'b0 || n >= 40) begin
      $display("FAIL wrap_stop got busy %b after %0d cycles exp 0", busy, n);
      n_err++;
    end
    continuo = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    saida_ready = 1'b1; continuo = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    saida_ready = 1'b0;
    cycle();
    n_vec++;
    if ({saida_valid, sel} !== {1'b1, 2'd1}) begin
      $display("FAIL rstmid_pre got %b exp %b", {saida_valid, sel}, {1'b1, 2'd1});
      n_err++;
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({sel, saida, saida_valid, busy, done} !== 9'd0) begin
      $display("FAIL rstmid_async got %b exp 0", {sel, saida, saida_valid, busy, done});
      n_err++;
    end
    cycle();
    reset = 1'b0;
    cycle();
    n_vec++;
    if ({saida_valid, busy} !== 2'b00) begin
      $display("FAIL rstmid_idle got %b exp 00", {saida_valid, busy});
      n_err++;
    end
`ifndef SKIP_EMPTY_EN
    saida_ready = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    n_vec++;
    if ({saida_valid, sel, saida} !== {1'b1, 2'd0, 4'd0}) begin
      $display("FAIL rstmid_cleared got %b exp %b", {saida_valid, sel, saida},
               {1'b1, 2'd0, 4'd0});
      n_err++;
    end
    drain(n);
`endif
  endtask

`ifdef SKIP_EMPTY_EN
  task automatic test_skip_empty();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    saida_ready = 1'b1; continuo = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    n_vec++;
    if ({done, saida_valid} !== 2'b10) begin
      $display("FAIL skip_none_done got %b exp 10", {done, saida_valid});
      n_err++;
    end
    cycle();
    n_vec++;
    if ({done, busy, saida_valid} !== 3'b000) begin
      $display("FAIL skip_none_idle got %b exp 000", {done, busy, saida_valid});
      n_err++;
    end
    wr(2'd1, 4'd5);
    wr(2'd3, 4'd7);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    n_vec++;
    if ({saida_valid, sel, saida} !== {1'b1, 2'd1, 4'd5}) begin
      $display("FAIL skip_ch1 got %b exp %b", {saida_valid, sel, saida}, {1'b1, 2'd1, 4'd5});
      n_err++;
    end
    cycle();
    cycle();
    n_vec++;
    if ({saida_valid, sel, saida} !== {1'b1, 2'd3, 4'd7}) begin
      $display("FAIL skip_ch3 got %b exp %b", {saida_valid, sel, saida}, {1'b1, 2'd3, 4'd7});
      n_err++;
    end
    cycle();
    n_vec++;
    if ({done, saida_valid} !== 2'b10) begin
      $display("FAIL skip_done got %b exp 10", {done, saida_valid});
      n_err++;
    end
    cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_single_sweep();
    test_write_during_load();
    test_backpressure();
    test_cont_stop();
    test_wrap();
    test_reset_mid();
`ifdef SKIP_EMPTY_EN
    test_skip_empty();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
